// File: rtl/plru_cam.sv
// plru_cam: multi-port CAM with registered lookups, self-allocating insert, invalidate, flush.
// Full-victim comes from a PLRU tree when CAM_PLRU_EN is defined, else from a round-robin pointer.

module plru_cam_match #(
    parameter int N  = 4,
    parameter int KW = 32,
    parameter int IW = 2
) (
    input  logic [N-1:0]         i_valid,
    input  logic [N-1:0][KW-1:0] i_keys,
    input  logic                 i_en,
    input  logic [KW-1:0]        i_key,
    output logic                 o_hit,
    output logic [IW-1:0]        o_idx
);
    // Keys are never duplicated, so at most one entry matches; lowest index wins anyway.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int e = N - 1; e >= 0; e--) begin
            if (i_en && i_valid[e] && (i_keys[e] == i_key)) begin
                o_hit = 1'b1;
                o_idx = IW'(e);
            end
        end
    end
endmodule

module plru_cam #(
    parameter int  NUM_ENTRIES      = 4,
    parameter int  KEY_WIDTH        = 32,
    parameter int  NUM_LOOKUP_PORTS = 2,
    localparam int INDEX_WIDTH      = $clog2(NUM_ENTRIES),
    localparam int CW               = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_LOOKUP_PORTS-1:0]                   lookup_en,
    input  logic [NUM_LOOKUP_PORTS-1:0][KEY_WIDTH-1:0]    lookup_key,
    output logic [NUM_LOOKUP_PORTS-1:0]                   lookup_hit,
    output logic [NUM_LOOKUP_PORTS-1:0][INDEX_WIDTH-1:0]  lookup_idx,
    input  logic                                          insert_en,
    input  logic [KEY_WIDTH-1:0]                          insert_key,
    output logic                                          insert_done,
    output logic [INDEX_WIDTH-1:0]                        insert_idx,
    output logic                                          insert_dup,
    output logic                                          insert_evicted,
    output logic [KEY_WIDTH-1:0]                          insert_evict_key,
    input  logic                                          invalidate_en,
    input  logic [KEY_WIDTH-1:0]                          invalidate_key,
    input  logic                                          flush_en,
    output logic [CW-1:0]                                 valid_count
);
    localparam int N  = NUM_ENTRIES;
    localparam int IW = INDEX_WIDTH;
    localparam int NP = NUM_LOOKUP_PORTS;

    logic [N-1:0]                r_valid;
    logic [N-1:0][KEY_WIDTH-1:0] r_keys;
    logic [CW-1:0]               r_count;

    logic [NP-1:0]               r_lk_hit;
    logic [NP-1:0][IW-1:0]       r_lk_idx;
    logic                        r_ins_done;
    logic [IW-1:0]               r_ins_idx;
    logic                        r_ins_dup;
    logic                        r_ins_ev;
    logic [KEY_WIDTH-1:0]        r_ins_ek;

    logic [NP-1:0]               w_lk_hit;
    logic [NP-1:0][IW-1:0]       w_lk_idx;
    logic                        w_ins_hit;
    logic [IW-1:0]               w_ins_idx;
    logic                        w_inv_hit;
    logic [IW-1:0]               w_inv_idx;
    logic [IW-1:0]               w_free_idx;
    logic [IW-1:0]               w_victim;
    logic                        w_full;
    logic                        w_ins_acc;
    logic                        w_evict;
    logic [IW-1:0]               w_ins_slot;

    for (genvar p = 0; p < NP; p++) begin : g_lk
        plru_cam_match #(.N(N), .KW(KEY_WIDTH), .IW(IW)) u_match (
            .i_valid (r_valid),
            .i_keys  (r_keys),
            .i_en    (lookup_en[p]),
            .i_key   (lookup_key[p]),
            .o_hit   (w_lk_hit[p]),
            .o_idx   (w_lk_idx[p])
        );
    end

    plru_cam_match #(.N(N), .KW(KEY_WIDTH), .IW(IW)) u_ins_match (
        .i_valid (r_valid),
        .i_keys  (r_keys),
        .i_en    (insert_en),
        .i_key   (insert_key),
        .o_hit   (w_ins_hit),
        .o_idx   (w_ins_idx)
    );

    plru_cam_match #(.N(N), .KW(KEY_WIDTH), .IW(IW)) u_inv_match (
        .i_valid (r_valid),
        .i_keys  (r_keys),
        .i_en    (invalidate_en),
        .i_key   (invalidate_key),
        .o_hit   (w_inv_hit),
        .o_idx   (w_inv_idx)
    );

    always_comb begin
        w_free_idx = '0;
        for (int e = N - 1; e >= 0; e--) begin
            if (!r_valid[e]) w_free_idx = IW'(e);
        end
    end

    assign w_full     = &r_valid;
    assign w_ins_acc  = insert_en && !flush_en;
    assign w_evict    = w_ins_acc && !w_ins_hit && w_full;
    assign w_ins_slot = w_ins_hit ? w_ins_idx : (w_full ? w_victim : w_free_idx);

`ifdef CAM_PLRU_EN
    // Heap-ordered tree: node 1 is the root, children of n are 2n and 2n+1.
    logic [N-1:1] r_plru;
    logic [N-1:1] w_plru_nxt;

    function automatic logic [N-1:1] f_touch(input logic [N-1:1] t, input logic [IW-1:0] e);
        logic [N-1:1] r;
        int           node;
        r    = t;
        node = 1;
        for (int l = 0; l < IW; l++) begin
            r[node] = ~e[IW-1-l];
            node    = 2 * node + (e[IW-1-l] ? 1 : 0);
        end
        return r;
    endfunction

    always_comb begin
        int node;
        w_victim = '0;
        node     = 1;
        for (int l = 0; l < IW; l++) begin
            w_victim[IW-1-l] = r_plru[node];
            node             = 2 * node + (r_plru[node] ? 1 : 0);
        end
    end

    // Lookup touches first in port order, the insert touch last.
    always_comb begin
        w_plru_nxt = r_plru;
        for (int p = 0; p < NP; p++) begin
            if (w_lk_hit[p]) w_plru_nxt = f_touch(w_plru_nxt, w_lk_idx[p]);
        end
        if (w_ins_acc) w_plru_nxt = f_touch(w_plru_nxt, w_ins_slot);
    end

    always_ff @(posedge clk) begin
        if (reset || flush_en) r_plru <= '0;
        else                   r_plru <= w_plru_nxt;
    end
`else
    logic [IW-1:0] r_rr;

    assign w_victim = r_rr;

    always_ff @(posedge clk) begin
        if (reset || flush_en) r_rr <= '0;
        else if (w_evict)      r_rr <= r_rr + IW'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= '0;
            r_keys     <= '0;
            r_count    <= '0;
            r_lk_hit   <= '0;
            r_lk_idx   <= '0;
            r_ins_done <= 1'b0;
            r_ins_idx  <= '0;
            r_ins_dup  <= 1'b0;
            r_ins_ev   <= 1'b0;
            r_ins_ek   <= '0;
        end else begin
            r_lk_hit   <= w_lk_hit;
            r_lk_idx   <= w_lk_idx;
            r_ins_done <= w_ins_acc;
            r_ins_idx  <= w_ins_acc ? w_ins_slot : '0;
            r_ins_dup  <= w_ins_acc && w_ins_hit;
            r_ins_ev   <= w_evict;
            r_ins_ek   <= w_evict ? r_keys[w_victim] : '0;
            if (flush_en) begin
                r_valid <= '0;
                r_count <= '0;
            end else if (w_ins_acc) begin
                if (!w_ins_hit) begin
                    r_valid[w_ins_slot] <= 1'b1;
                    r_keys[w_ins_slot]  <= insert_key;
                    if (!w_full) r_count <= r_count + CW'(1);
                end
            end else if (w_inv_hit) begin
                r_valid[w_inv_idx] <= 1'b0;
                r_count            <= r_count - CW'(1);
            end
        end
    end

`ifdef SIMULATION
    always @(posedge clk) begin
        if (!reset && insert_en && invalidate_en) begin
            $display("plru_cam: insert_en and invalidate_en asserted together");
            $finish;
        end
    end
`endif

    assign lookup_hit       = r_lk_hit;
    assign lookup_idx       = r_lk_idx;
    assign insert_done      = r_ins_done;
    assign insert_idx       = r_ins_idx;
    assign insert_dup       = r_ins_dup;
    assign insert_evicted   = r_ins_ev;
    assign insert_evict_key = r_ins_ek;
    assign valid_count      = r_count;
endmodule

// File: tb/tb_plru_cam.sv
// Scoreboard bench for plru_cam: expectations queued at drive time, popped one cycle later.
module tb_plru_cam;
    localparam int N  = 4;
    localparam int KW = 32;
    localparam int NP = 2;
    localparam int IW = 2;
    localparam int CW = 3;

    localparam logic [KW-1:0] KA = 32'hA000_000A, KB = 32'hB000_000B, KC = 32'hC000_000C,
                              KD = 32'hD000_000D, KE = 32'hE000_000E, KF = 32'hF000_000F,
                              KG = 32'h6000_0006, KH = 32'h7000_0007, KX = 32'h1234_5678,
                              KZ = 32'h0BAD_0BAD, KK = 32'h4000_0004, KL = 32'h5000_0005;

`ifdef CAM_PLRU_EN
    localparam logic [IW-1:0] F_IDX  = 2, E2_IDX = 2, X_IDX = 3, E_LOC = 2;
    localparam logic [KW-1:0] F_EK   = KC, E2_EK = KC, X_EK = KD;
`else
    localparam logic [IW-1:0] F_IDX  = 1, E2_IDX = 0, X_IDX = 1, E_LOC = 0;
    localparam logic [KW-1:0] F_EK   = KB, E2_EK = KA, X_EK = KB;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NP-1:0]            lookup_en = '0;
    logic [NP-1:0][KW-1:0]    lookup_key = '0;
    logic [NP-1:0]            lookup_hit;
    logic [NP-1:0][IW-1:0]    lookup_idx;
    logic                     insert_en = 1'b0;
    logic [KW-1:0]            insert_key = '0;
    logic                     insert_done;
    logic [IW-1:0]            insert_idx;
    logic                     insert_dup;
    logic                     insert_evicted;
    logic [KW-1:0]            insert_evict_key;
    logic                     invalidate_en = 1'b0;
    logic [KW-1:0]            invalidate_key = '0;
    logic                     flush_en = 1'b0;
    logic [CW-1:0]            valid_count;

    plru_cam #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .NUM_LOOKUP_PORTS(NP)) dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_en        (lookup_en),
        .lookup_key       (lookup_key),
        .lookup_hit       (lookup_hit),
        .lookup_idx       (lookup_idx),
        .insert_en        (insert_en),
        .insert_key       (insert_key),
        .insert_done      (insert_done),
        .insert_idx       (insert_idx),
        .insert_dup       (insert_dup),
        .insert_evicted   (insert_evicted),
        .insert_evict_key (insert_evict_key),
        .invalidate_en    (invalidate_en),
        .invalidate_key   (invalidate_key),
        .flush_en         (flush_en),
        .valid_count      (valid_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          done;
        logic [IW-1:0] idx;
        logic          dup;
        logic          ev;
        logic [KW-1:0] ek;
    } ins_t;

    typedef struct {
        logic          hit;
        logic [IW-1:0] idx;
    } lk_t;

    ins_t q_ins[$];
    lk_t  q_lk0[$];
    lk_t  q_lk1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ins(input logic [KW-1:0] k, input logic [IW-1:0] idx, input logic dup,
                       input logic ev, input logic [KW-1:0] ek);
        ins_t e;
        insert_en  = 1'b1;
        insert_key = k;
        e = '{1'b1, idx, dup, ev, ek};
        q_ins.push_back(e);
    endtask

    task automatic lk(input int p, input logic [KW-1:0] k, input logic hit, input logic [IW-1:0] idx);
        lk_t e;
        lookup_en[p]  = 1'b1;
        lookup_key[p] = k;
        e = '{hit, idx};
        if (p == 0) q_lk0.push_back(e);
        else        q_lk1.push_back(e);
    endtask

    // Any output without a queued expectation must be idle (all zero).
    task automatic tick(input int vc, input string tag);
        ins_t ei;
        lk_t  e0;
        lk_t  e1;
        ei = '{1'b0, '0, 1'b0, 1'b0, '0};
        e0 = '{1'b0, '0};
        e1 = '{1'b0, '0};
        @(posedge clk);
        #1;
        insert_en     = 1'b0;
        invalidate_en = 1'b0;
        flush_en      = 1'b0;
        lookup_en     = '0;
        if (q_ins.size() > 0) ei = q_ins.pop_front();
        if (q_lk0.size() > 0) e0 = q_lk0.pop_front();
        if (q_lk1.size() > 0) e1 = q_lk1.pop_front();
        check({tag, ".done"}, 64'(insert_done), 64'(ei.done));
        check({tag, ".idx"},  64'(insert_idx), 64'(ei.idx));
        check({tag, ".dup"},  64'(insert_dup), 64'(ei.dup));
        check({tag, ".ev"},   64'(insert_evicted), 64'(ei.ev));
        check({tag, ".ek"},   64'(insert_evict_key), 64'(ei.ek));
        check({tag, ".hit0"}, 64'(lookup_hit[0]), 64'(e0.hit));
        check({tag, ".idx0"}, 64'(lookup_idx[0]), 64'(e0.idx));
        check({tag, ".hit1"}, 64'(lookup_hit[1]), 64'(e1.hit));
        check({tag, ".idx1"}, 64'(lookup_idx[1]), 64'(e1.idx));
        check({tag, ".vc"},   64'(valid_count), 64'(vc));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        tick(0, "rst");
        reset = 1'b0;

        ins(KA, 0, 0, 0, '0); tick(1, "insA");
        ins(KB, 1, 0, 0, '0); tick(2, "insB");
        ins(KC, 2, 0, 0, '0); tick(3, "insC");
        ins(KD, 3, 0, 0, '0); tick(4, "insD");
        ins(KE, 0, 0, 1, KA); tick(4, "insE");
        ins(KF, F_IDX, 0, 1, F_EK); tick(4, "insF");
        lk(0, KE, 1, 0); lk(1, KF, 1, F_IDX); tick(4, "lkEF");
        lk(0, KA, 0, 0); tick(4, "lkA_gone");
        flush_en = 1'b1; lk(0, KD, 1, 3); tick(0, "flush");
        lk(0, KD, 0, 0); lk(1, KE, 0, 0); tick(0, "postflush");

        ins(KA, 0, 0, 0, '0); tick(1, "insA2");
        ins(KB, 1, 0, 0, '0); tick(2, "insB2");
        ins(KC, 2, 0, 0, '0); tick(3, "insC2");
        ins(KD, 3, 0, 0, '0); tick(4, "insD2");
        lk(0, KA, 1, 0); lookup_key[1] = KA; tick(4, "lkA_en");
        ins(KE, E2_IDX, 0, 1, E2_EK); tick(4, "insE2");
        ins(KB, 1, 1, 0, '0); tick(4, "dupB");
        ins(KX, X_IDX, 0, 1, X_EK); lk(0, KX, 0, 0); tick(4, "insX");
        lk(1, KX, 1, X_IDX); tick(4, "lkX");
        invalidate_en = 1'b1; invalidate_key = KE; lk(0, KE, 1, E_LOC); tick(3, "invE");
        ins(KG, E_LOC, 0, 0, '0); lk(0, KE, 0, 0); tick(4, "insG");
        invalidate_en = 1'b1; invalidate_key = KZ; tick(4, "invZ");
        flush_en = 1'b1; insert_en = 1'b1; insert_key = KH; lk(0, KG, 1, E_LOC); tick(0, "flushH");
        lk(0, KH, 0, 0); lk(1, KG, 0, 0); tick(0, "postflushH");

        ins(KK, 0, 0, 0, '0); tick(1, "insK");
        reset = 1'b1; insert_en = 1'b1; insert_key = KL; lk(0, KK, 0, 0); tick(0, "rstmid");
        reset = 1'b0;
        lk(0, KK, 0, 0); ins(KL, 0, 0, 0, '0); tick(1, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/plru_cam.md
# plru_cam

Multi-port content-addressable memory with registered lookups, self-allocating insert, key-based invalidate, flush, and pseudo-LRU replacement. It is the next-generation CAM used by TLBs and miss-tracking structures in the core. When full, it picks the victim itself and reports what was evicted, so clients no longer manage slot indices.

## Interface
- NUM_ENTRIES, 4, number of entries; power of two, ≥2
- KEY_WIDTH, 32, key width in bits
- NUM_LOOKUP_PORTS, 2, independent lookup ports, ≥1
- INDEX_WIDTH, $clog2(NUM_ENTRIES), derived
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- lookup_en  in  NUM_LOOKUP_PORTS  per-port lookup request
- lookup_key  in  NUM_LOOKUP_PORTS×KEY_WIDTH  per-port key
- lookup_hit  out  NUM_LOOKUP_PORTS  registered hit, one cycle after request
- lookup_idx  out  NUM_LOOKUP_PORTS×INDEX_WIDTH  registered matching index
- insert_en  in  1  insert request
- insert_key  in  KEY_WIDTH  key to insert
- insert_done  out  1  one-cycle pulse, one cycle after an accepted insert
- insert_idx  out  INDEX_WIDTH  slot holding the key
- insert_dup  out  1  key was already present; no allocation was made
- insert_evicted  out  1  a valid entry was replaced
- insert_evict_key  out  KEY_WIDTH  key of the replaced entry
- invalidate_en  in  1  invalidate by key
- invalidate_key  in  KEY_WIDTH  key to invalidate
- flush_en  in  1  invalidate all entries
- valid_count  out  $clog2(NUM_ENTRIES+1)  number of valid entries

## Operation
- Every match uses the state present before the clock edge. A key inserted in cycle N is first visible to a lookup presented in cycle N+1.
- Lookup: if lookup_en[p] is high, compare the key against all valid entries. Register hit and idx. When there is no hit, or lookup_en is low, lookup_hit[p]=0 and lookup_idx[p]=0.
- A lookup hit marks the entry most-recently-used. Updates apply in ascending port order.
- Insert on a hit: insert_dup=1, insert_idx = existing slot, and the entry becomes MRU. Nothing else changes.
- Insert on a miss, with an invalid slot available: take the lowest-numbered invalid slot. insert_evicted=0.
- Insert on a miss, when full: take the victim chosen by the replacement policy. insert_evicted=1 and insert_evict_key = the old key.
- The inserted slot becomes valid and MRU. Its recency update is applied after all lookup updates in the same cycle.
- Invalidate: clear the valid bit of the matching entry. A miss has no effect. Recency state is untouched.
- Flush: clear all valid bits and reset recency state to zero.
- Priority: flush overrides insert and invalidate in the same cycle. A dropped insert produces no insert_done. Lookups in the flush cycle still report pre-flush results.
- insert_en and invalidate_en in the same cycle is illegal. Under SIMULATION this triggers $display and $finish.
- Inserting a key that duplicates an existing entry never creates a second copy; it is the insert_dup path.
- valid_count tracks the valid bits exactly: +1 on a non-dup insert into an invalid slot, −1 on an invalidate hit, 0 after flush. Saturation cannot occur by construction.
- PLRU tree: NUM_ENTRIES−1 node bits, one bit per node.
  - Bit value 0 means the left subtree is LRU.
  - Touching an entry sets every node on its path to point away from it.
  - The victim is found by following the bits from the root.

## Timing
- Lookup latency is 1 cycle. One lookup per port per cycle, fully pipelined.
- Insert latency is 1 cycle. Back-to-back inserts every cycle are supported; each insert sees the previous one's result.
- A lookup in the same cycle as an insert of the same key misses. A lookup in the same cycle as an invalidate of the same key hits.
- Reset values: all valid bits 0, PLRU bits 0, all outputs 0, valid_count 0.
- Reset asserted mid-operation suppresses any insert_done or lookup_hit that would be registered on that edge.

## Configuration
- CAM_PLRU_EN defined: the full-victim is chosen by the PLRU tree as described above.
- CAM_PLRU_EN undefined:
  - The PLRU tree is omitted.
  - The full-victim comes from a round-robin pointer, reset to 0, which increments (wrapping) on each eviction.
  - Lookup hits do not affect victim choice.

## Test plan
- NUM_ENTRIES=4. Insert A,B,C,D in consecutive cycles -> insert_idx 0,1,2,3, insert_evicted=0, valid_count=4.
- After that, insert E -> idx 0, evicted A. With CAM_PLRU_EN undefined: idx 0, then insert F -> idx 1.
- A,B,C,D loaded, lookup port 0 = A, then insert E -> idx 2, evict_key C with CAM_PLRU_EN defined; idx 0 without.
- Insert B while B is present -> insert_dup=1, insert_idx=1, valid_count unchanged.
- Insert X and lookup X in the same cycle -> lookup_hit=0. Lookup X in the next cycle -> hit, correct idx.
- Invalidate C, then insert G -> idx 2, evicted=0. Flush together with insert H -> no insert_done, valid_count=0, all following lookups miss.
